// File: rtl/cmp_pkg.sv
// Shared definitions for the compare unit: op encoding and flag bit positions.
package cmp_pkg;

    typedef enum logic [2:0] {
        OP_SLT  = 3'b000,
        OP_SGT  = 3'b001,
        OP_SLTU = 3'b010,
        OP_SGTU = 3'b011,
        OP_EQ   = 3'b100,
        OP_NE   = 3'b101,
        OP_MIN  = 3'b110,
        OP_MAX  = 3'b111
    } cmp_op_e;

    localparam int FLAGS_W  = 3;
    localparam int FLAG_EQ  = 2;
    localparam int FLAG_SLT = 1;
    localparam int FLAG_ULT = 0;

endpackage

// File: rtl/cmp_core.sv
// Combinational compare datapath: selected result plus {eq, slt, ult} flags.
// Zero latency; no state, so no backpressure of its own.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   src1,
    input  logic [WIDTH-1:0]   src2,
    input  logic [2:0]         op,
    output logic [WIDTH-1:0]   result,
    output logic [FLAGS_W-1:0] flags
);

    logic eq;
    logic slt;
    logic ult;
    logic hit;

    always_comb begin
        eq  = (src1 == src2);
        slt = ($signed(src1) < $signed(src2));
        ult = (src1 < src2);

        flags           = '0;
        flags[FLAG_EQ]  = eq;
        flags[FLAG_SLT] = slt;
        flags[FLAG_ULT] = ult;

        hit    = 1'b0;
        result = '0;
        case (op)
            OP_SLT:  hit = slt;
            OP_SGT:  hit = !slt && !eq;
            OP_SLTU: hit = ult;
            OP_SGTU: hit = !ult && !eq;
            OP_EQ:   hit = eq;
            OP_NE:   hit = !eq;
            default: hit = 1'b0;
        endcase

        if (op == OP_MIN) begin
            // equal operands fall through to src1
            result = (slt || eq) ? src1 : src2;
        end else if (op == OP_MAX) begin
            result = slt ? src2 : src1;
        end else begin
            result = {{(WIDTH-1){1'b0}}, hit};
        end
    end

endmodule

// File: rtl/cmp_unit.sv
// Pipelined compare unit: optional operand stage S1, then result stage S2.
// Latency 2 cycles (REG_IN=1) or 1 (REG_IN=0); a stalled S2 holds and backs up into S1/in_ready.
module cmp_unit
    import cmp_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int REG_IN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   src1,
    input  logic [WIDTH-1:0]   src2,
    input  logic [2:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   comp_out,
    output logic [FLAGS_W-1:0] flags
);

    logic               s2_vld;
    logic [WIDTH-1:0]   s2_res;
    logic [FLAGS_W-1:0] s2_flags;
    logic               s2_load;

    logic               feed_vld;
    logic [WIDTH-1:0]   feed_src1;
    logic [WIDTH-1:0]   feed_src2;
    logic [2:0]         feed_op;

    logic [WIDTH-1:0]   core_res;
    logic [FLAGS_W-1:0] core_flags;

    assign s2_load = !s2_vld || out_ready;

    generate
        if (REG_IN != 0) begin : g_s1
            logic             s1_vld;
            logic [WIDTH-1:0] s1_src1;
            logic [WIDTH-1:0] s1_src2;
            logic [2:0]       s1_op;
            logic             s1_load;

            // S1 refills in the same cycle it hands its contents to S2
            assign s1_load  = !s1_vld || s2_load;
            assign in_ready = !rst && s1_load;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_vld  <= 1'b0;
                    s1_src1 <= '0;
                    s1_src2 <= '0;
                    s1_op   <= '0;
                end else if (s1_load) begin
                    s1_vld <= in_valid;
                    if (in_valid) begin
                        s1_src1 <= src1;
                        s1_src2 <= src2;
                        s1_op   <= op;
                    end
                end
            end

            assign feed_vld  = s1_vld;
            assign feed_src1 = s1_src1;
            assign feed_src2 = s1_src2;
            assign feed_op   = s1_op;
        end else begin : g_bypass
            assign in_ready  = !rst && s2_load;
            assign feed_vld  = in_valid;
            assign feed_src1 = src1;
            assign feed_src2 = src2;
            assign feed_op   = op;
        end
    endgenerate

    cmp_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .src1   (feed_src1),
        .src2   (feed_src2),
        .op     (feed_op),
        .result (core_res),
        .flags  (core_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld   <= 1'b0;
            s2_res   <= '0;
            s2_flags <= '0;
        end else if (s2_load) begin
            s2_vld <= feed_vld;
            if (feed_vld) begin
                s2_res   <= core_res;
                s2_flags <= core_flags;
            end
        end
    end

    assign out_valid = s2_vld;
    assign comp_out  = s2_res;
    assign flags     = s2_flags;

endmodule

// File: doc/cmp_unit.md
CMP_UNIT -- requirements
Module: cmp_unit

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32: operand and result width in bits, minimum 2.
REQ-002 The block SHALL take parameter REG_IN, default 1: 1 adds an operand register stage, 0 bypasses it.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: src1/src2/op are valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port src1, input, WIDTH bits: first operand.
REQ-008 The block SHALL have port src2, input, WIDTH bits: second operand.
REQ-009 The block SHALL have port op, input, 3 bits: operation select.
REQ-010 The block SHALL have port out_valid, output, 1 bit: comp_out and flags are valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port comp_out, output, WIDTH bits: the result.
REQ-013 The block SHALL have port flags, output, 3 bits: {eq, slt, ult} for the delivered operands.

Function
REQ-014 Op encoding SHALL be: 000 SLT, 001 SGT, 010 SLTU, 011 SGTU, 100 EQ, 101 NE, 110 MIN (signed), 111 MAX (signed).
REQ-015 Ops 000-101 SHALL give 1 zero-extended to WIDTH when the condition holds, else 0.
REQ-016 MIN/MAX SHALL return the signed smaller/larger operand; on equal operands they SHALL return src1.
REQ-017 Signed compares SHALL treat bit WIDTH-1 as the sign; unsigned compares SHALL use plain magnitude.
REQ-018 flags SHALL be computed for every op, independent of op.
REQ-019 A transfer SHALL occur on a cycle where valid and ready are both high, on either the input or the output side.
REQ-020 Pipeline: an optional stage S1 (operand regs, present when REG_IN=1), then stage S2 (result regs), each with its own valid bit.
REQ-021 Latency from input transfer to out_valid SHALL be 2 cycles with REG_IN=1 and 1 cycle with REG_IN=0, given no stall.
REQ-022 With out_ready held high, throughput SHALL be one result per cycle.
REQ-023 S2 SHALL load when it is empty or its result transfers this cycle; S1 SHALL load when it is empty or it advances into S2.
REQ-024 in_ready SHALL equal the S1 load condition (S2 load condition when REG_IN=0), with no combinational path from in_valid.
REQ-025 While out_valid=1 and out_ready=0, comp_out and flags SHALL hold stable, and out_valid SHALL stay high.
REQ-026 When a stage is not loading, its registers SHALL retain their values; no request SHALL be dropped or duplicated.
REQ-027 If S2 drains while S1 refills in the same cycle, both moves SHALL complete that cycle.

Reset
REQ-028 While rst=1, all stage valid bits SHALL be 0, comp_out and flags SHALL be 0, and in_ready SHALL be 0.
REQ-029 Asserting rst mid-operation SHALL discard in-flight requests, with no output produced for them.
REQ-030 in_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-031 Package cmp_pkg SHALL hold the op encoding constants and the flags bit positions.
REQ-032 A combinational sub-module cmp_core (WIDTH, src1, src2, op -> result, flags) SHALL contain all compare logic; cmp_unit holds the handshake and registers.

Verification
REQ-033 SLT on src1=0xFFFFFFFF, src2=0x00000001 -> comp_out=1, flags=3'b010; repeated as SLTU -> comp_out=0.
REQ-034 MAX on src1=0x80000000, src2=0x7FFFFFFF -> comp_out=0x7FFFFFFF; MIN on equal 0x5 operands -> comp_out=0x5, flags=3'b100.
REQ-035 Back-to-back stream of 8 requests with out_ready=1 -> 8 results in order, the first 2 cycles after the first input transfer, one per cycle.
REQ-036 out_ready held 0 for 4 cycles after the first result -> output holds stable; in_ready drops after 2 (REG_IN=1) accepted requests; all results arrive in order after release.
REQ-037 rst pulsed with 2 requests in flight -> out_valid=0 on the next cycle; no stale results ever appear.
REQ-038 WIDTH=8, SGTU on src1=0x80, src2=0x7F -> comp_out=8'h01; SGT on the same operands -> comp_out=8'h00.
